mont_encoder: RTL and testbench
===============================

// Module: mont_encoder
// PURPOSE
//  Converts an operand into the Montgomery domain: o_result = (i_a * 2^SHIFTS) mod i_N.
//  Counterpart of the Montgomery multiplier, whose output leaves the domain by a factor 2^-256.
//  Bit-serial modular doubling, one step per clock. Sits in front of the multiplier datapath.
// PARAMETERS
//  WIDTH   256  operand width of i_N, i_a and o_result
//  SHIFTS  256  exponent k of R = 2^k (number of modular doublings)
// PORTS
//  i_clk       in   1      clock; all logic on rising edge
//  i_rst       in   1      synchronous, active-high reset
//  i_start     in   1      start request; sampled only in S_IDLE
//  i_N         in   WIDTH  modulus, latched on accepted start
//  i_a         in   WIDTH  operand, latched on accepted start
//  o_busy      out  1      high in S_CALC and S_DONE
//  o_result    out  WIDTH  result; held until the next completion
//  o_finished  out  1      single-cycle completion pulse
// BEHAVIOUR
//  - Reset (i_rst=1 at an edge): state S_IDLE, o_result=0, o_finished=0, o_busy=0, counter=0; aborts any op.
//  - States: S_IDLE -> S_CALC on i_start; S_CALC -> S_DONE after last step; S_DONE -> S_IDLE always.
//  - Accept: at the edge with S_IDLE and i_start=1, latch N; x = (i_a >= i_N) ? i_a - i_N : i_a; cnt = 0.
//  - S_CALC step: t = {x,1'b0} (WIDTH+1 bits); x = (t >= {1'b0,N}) ? t - N : t; cnt++.
//    Invariant x < N keeps one conditional subtract sufficient; no other width growth.
//  - Step with cnt == SHIFTS-1 is the last; go S_DONE, register o_result = x, o_finished = 1.
//  - Latency: o_finished high in the cycle after edge SHIFTS+1 counted from the accepting edge (default 257 edges).
//  - S_DONE: o_finished=1 for exactly that cycle; i_start ignored; next cycle S_IDLE, o_finished=0.
//  - i_start while o_busy=1: ignored, no queueing; input ports may change freely after acceptance.
//  - N == 0 latched: skip S_CALC; next edge -> S_DONE with o_result = 0 (latency 1 edge).
//  - N == 1: normal run, o_result = 0.
//  - Without the feature, operand must satisfy i_a < 2*i_N; otherwise o_result is unspecified (no hang).
//  - Counter width $clog2(WIDTH+SHIFTS+1); no wrap inside a legal run.
// CONFIGURATION
//  MONT_ENC_REDUCE_EN defined:
//   - Any i_a < 2^WIDTH accepted. At accept x = 0; first WIDTH steps process i_a MSB-first:
//     t = {x, a_bit}; x = (t >= N) ? t - N : t. Then SHIFTS doubling steps as above.
//   - Latency becomes WIDTH+SHIFTS edges to S_DONE; N == 0 shortcut unchanged.
//  MONT_ENC_REDUCE_EN undefined: single pre-subtract at accept, latency SHIFTS as above.
// STRUCTURE
//  - mont_pkg: state_t enum {S_IDLE, S_CALC, S_DONE}; localparam MONT_WIDTH = 256.
//  - Sub-module mod_double_step (combinational): inputs x, bit_in, N; output
//    ({x,bit_in} >= N) ? {x,bit_in} - N : {x,bit_in}; shared by both phases.
//  - Top: FSM, counter, x/N/a registers, result register.
// TESTING
//  1. Default params, N=2^255+1, a=1 -> o_result=2^255-1, o_finished at edge 257, one cycle wide.
//  2. WIDTH=8,SHIFTS=8, N=13, a=5 -> o_result=6 after 9 edges; a=20 (>=N,<2N) -> 20*256 mod 13 = 11.
//  3. N=1, a=0 -> 0 after full latency; N=0, a=7 -> o_result=0, o_finished 2 edges after accept.
//  4. i_start pulsed every cycle during run, new i_a driven -> exactly one o_finished, result of first op.
//  5. i_rst=1 at step 100 -> next cycle o_busy=0,o_result=0; new start then completes correctly.
//  6. MONT_ENC_REDUCE_EN, WIDTH=8,SHIFTS=8, N=13, a=200 -> o_result=6 after 17 edges.

Source files
------------

// File: rtl/mont_encoder_pkg.sv
// Shared types and constants for the Montgomery-domain encoder.
// Used by mont_encoder and its modular-doubling datapath.
package mont_pkg;

    localparam int MONT_WIDTH = 256;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mont_encoder_step.sv
// One modular step: y = ({x,bit_in} >= n) ? {x,bit_in} - n : {x,bit_in}.
// Relies on x < n, so a single conditional subtract keeps y < n.
module mod_double_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] x,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] n_in,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] y_full;
    logic           unused_msb;

    always_comb begin
        t      = {x, bit_in};
        n_ext  = {1'b0, n_in};
        y_full = (t >= n_ext) ? (t - n_ext) : t;
    end

    // With x < n the reduced value always fits in WIDTH bits.
    assign y          = y_full[WIDTH-1:0];
    assign unused_msb = y_full[WIDTH];

endmodule

// File: rtl/mont_encoder.sv
// Montgomery-domain encoder: o_result = (i_a * 2^SHIFTS) mod i_N, one doubling per clock.
// Optional MONT_ENC_REDUCE_EN: accept any i_a by first reducing it MSB-first through the same step.
module mont_encoder
    import mont_pkg::*;
#(
    parameter int WIDTH  = MONT_WIDTH,
    parameter int SHIFTS = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_N,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished
);

    localparam int CW = $clog2(WIDTH + SHIFTS + 1);
`ifdef MONT_ENC_REDUCE_EN
    localparam int LAST = WIDTH + SHIFTS - 1;
`else
    localparam int LAST = SHIFTS - 1;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             finished_q, finished_d;
    logic [WIDTH-1:0] step_y;
    logic             step_bit;

`ifdef MONT_ENC_REDUCE_EN
    logic [WIDTH-1:0] a_q, a_d;

    // Operand bits feed in MSB-first; once shifted out, zeros turn the step into a pure doubling.
    assign step_bit = a_q[WIDTH-1];
`else
    logic [WIDTH-1:0] pre_x;

    assign step_bit = 1'b0;
    assign pre_x    = (i_a >= i_N) ? (i_a - i_N) : i_a;
`endif

    mod_double_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x      (x_q),
        .bit_in (step_bit),
        .n_in   (n_q),
        .y      (step_y)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        n_d        = n_q;
        result_d   = result_q;
        finished_d = 1'b0;
`ifdef MONT_ENC_REDUCE_EN
        a_d        = a_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CALC;
                    n_d     = i_N;
                    cnt_d   = '0;
`ifdef MONT_ENC_REDUCE_EN
                    x_d     = '0;
                    a_d     = i_a;
`else
                    x_d     = pre_x;
`endif
                end
            end
            S_CALC: begin
                if (n_q == '0) begin
                    state_d    = S_DONE;
                    result_d   = '0;
                    finished_d = 1'b1;
                end else begin
                    x_d   = step_y;
                    cnt_d = cnt_q + CW'(1);
`ifdef MONT_ENC_REDUCE_EN
                    a_d   = a_q << 1;
`endif
                    if (cnt_q == CW'(LAST)) begin
                        state_d    = S_DONE;
                        result_d   = step_y;
                        finished_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            n_q        <= '0;
            result_q   <= '0;
            finished_q <= 1'b0;
`ifdef MONT_ENC_REDUCE_EN
            a_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            n_q        <= n_d;
            result_q   <= result_d;
            finished_q <= finished_d;
`ifdef MONT_ENC_REDUCE_EN
            a_q        <= a_d;
`endif
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_result   = result_q;
    assign o_finished = finished_q;

endmodule

// File: tb/tb_mont_encoder.sv
// Directed bench for mont_encoder: a 256-bit instance and an 8-bit instance side by side.
// Expected results and latencies are hand-computed; MONT_ENC_REDUCE_EN selects the longer latency.
`timescale 1ns/1ps
module tb_mont_encoder;

`ifdef MONT_ENC_REDUCE_EN
    localparam int LAT_S = 8 + 8 + 1;
    localparam int LAT_B = 256 + 256 + 1;
`else
    localparam int LAT_S = 8 + 1;
    localparam int LAT_B = 256 + 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_b, busy_b, fin_b;
    logic [255:0] n_b, a_b, res_b;
    logic         start_s, busy_s, fin_s;
    logic [7:0]   n_s, a_s, res_s;

    int n_checks = 0;
    int n_fails  = 0;

    mont_encoder #(.WIDTH(256), .SHIFTS(256)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start_b),
        .i_N        (n_b),
        .i_a        (a_b),
        .o_busy     (busy_b),
        .o_result   (res_b),
        .o_finished (fin_b)
    );

    mont_encoder #(.WIDTH(8), .SHIFTS(8)) u_dut_s (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start_s),
        .i_N        (n_s),
        .i_a        (a_s),
        .o_busy     (busy_s),
        .o_result   (res_s),
        .o_finished (fin_s)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit big, input logic [255:0] n, input logic [255:0] a,
                          input logic [255:0] exp, input int lat, input string tag);
        int edges;
        if (big) begin
            start_b = 1'b1; n_b = n; a_b = a;
        end else begin
            start_s = 1'b1; n_s = n[7:0]; a_s = a[7:0];
        end
        @(posedge clk); #1;
        start_b = 1'b0;
        start_s = 1'b0;
        n_b = {8{$urandom}};
        a_b = {8{$urandom}};
        n_s = 8'($urandom);
        a_s = 8'($urandom);
        edges = 1;
        check({tag, "_busy"}, big ? busy_b : busy_s, 1);
        while (!(big ? fin_b : fin_s) && edges < 2000) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_lat"}, edges, lat);
        check({tag, "_res"}, big ? res_b : {248'd0, res_s}, exp);
        $display("op %s: N=%0h a=%0h result=%0h edges=%0d", tag, n, a,
                 big ? res_b : {248'd0, res_s}, edges);
        @(posedge clk); #1;
        check({tag, "_pulse"}, big ? fin_b : fin_s, 0);
        check({tag, "_idle"}, big ? busy_b : busy_s, 0);
    endtask

    logic [255:0] n_big, exp_big;
    int           pulses;
    logic [7:0]   got_s;

    initial begin
        n_big   = (256'd1 << 255) + 256'd1;
        exp_big = (256'd1 << 255) - 256'd1;
        rst = 1'b1;
        start_b = 1'b0; n_b = '0; a_b = '0;
        start_s = 1'b0; n_s = '0; a_s = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_b", busy_b, 0);
        check("rst_fin_b", fin_b, 0);
        check("rst_res_b", res_b, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_res_s", res_s, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, n_big, 256'd1, exp_big, LAT_B, "big_a1");
        run_op(1'b0, 256'd13, 256'd5, 256'd6, LAT_S, "s_a5");
        run_op(1'b0, 256'd13, 256'd20, 256'd11, LAT_S, "s_a20");
        run_op(1'b0, 256'd13, 256'd12, 256'd4, LAT_S, "s_a12");
        run_op(1'b0, 256'd13, 256'd0, 256'd0, LAT_S, "s_a0");
        run_op(1'b0, 256'd1, 256'd0, 256'd0, LAT_S, "s_n1");
        run_op(1'b0, 256'd0, 256'd7, 256'd0, 2, "s_n0");
`ifdef MONT_ENC_REDUCE_EN
        run_op(1'b0, 256'd13, 256'd200, 256'd6, LAT_S, "s_a200");
`endif

        // start held high and operands churned during a run: one completion only
        start_s = 1'b1; n_s = 8'd13; a_s = 8'd5;
        @(posedge clk); #1;
        pulses = 0;
        got_s  = '0;
        repeat (40) begin
            if (pulses == 0) begin
                start_s = 1'b1;
                n_s = 8'($urandom);
                a_s = 8'($urandom);
            end else begin
                start_s = 1'b0;
            end
            @(posedge clk); #1;
            if (fin_s) begin
                pulses++;
                got_s = res_s;
            end
        end
        start_s = 1'b0;
        check("busy_start_pulses", pulses, 1);
        check("busy_start_res", got_s, 6);
        $display("op busy_start: pulses=%0d result=%0h", pulses, got_s);

        // reset in the middle of a long run
        start_b = 1'b1; n_b = n_big; a_b = 256'd3;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("mid_busy_before", busy_b, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy_b, 0);
        check("mid_rst_res", res_b, 0);
        check("mid_rst_fin", fin_b, 0);
        $display("op mid_reset: busy=%0d result=%0h", busy_b, res_b);
        @(posedge clk); #1;
        run_op(1'b1, n_big, 256'd1, exp_big, LAT_B, "big_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
